// File: rtl/frame_packer.sv
// frame_packer: packs a serial 16-bit PCM stream into 32-sample frames and
// presents each frame with its address (done / next_module_ready handshake).
// A fill buffer plus an output slot let the next frame fill while one is waiting.
module frame_packer #(
   parameter int SAMPLES_PER_FRAME = 32,
   parameter int SAMPLE_W          = 16,
   parameter int ADDR_W            = 32,
   parameter int FRAME_BYTES       = 64
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic [SAMPLE_W-1:0]                         sample_in,
   input  logic                                        sample_valid,
   output logic                                        sample_ready,
   input  logic                                        flush,
   input  logic [ADDR_W-1:0]                           base_address,
   input  logic                                        load_base,
   input  logic                                        next_module_ready,
   output logic [ADDR_W-1:0]                           address_out,
   output logic [SAMPLES_PER_FRAME-1:0][SAMPLE_W-1:0]  audio_out,
   output logic                                        done
);

   localparam int CNT_W = $clog2(SAMPLES_PER_FRAME);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SAMPLES_PER_FRAME - 1);

   // Fill side state
   logic [SAMPLES_PER_FRAME-1:0][SAMPLE_W-1:0] r_fill;
   logic [CNT_W-1:0]                           r_fill_cnt;
   logic                                       r_fill_full;

   // Output slot state
   logic [SAMPLES_PER_FRAME-1:0][SAMPLE_W-1:0] r_out;
   logic                                       r_out_valid;
   logic [ADDR_W-1:0]                          r_addr_out;
   logic [ADDR_W-1:0]                          r_addr_next;

   // Per-edge decisions
   logic                                       w_accept;
   logic                                       w_flush;
   logic                                       w_complete;
   logic                                       w_slot_free;
   logic                                       w_move;
   logic [ADDR_W-1:0]                          w_addr_sel;
   logic [SAMPLES_PER_FRAME-1:0][SAMPLE_W-1:0] w_frame;

   assign sample_ready = !r_fill_full;
   assign w_accept     = sample_valid && !r_fill_full;
   // A flush only means something for a partial frame that is not already waiting.
   assign w_flush      = flush && (r_fill_cnt != '0) && !r_fill_full;
   assign w_complete   = (w_accept && (r_fill_cnt == LAST_IDX)) || w_flush;
   // The slot frees up either because it is empty or because downstream takes it now.
   assign w_slot_free  = !r_out_valid || next_module_ready;
   assign w_move       = w_slot_free && (r_fill_full || w_complete);
   assign w_addr_sel   = load_base ? base_address : r_addr_next;

   // Fill-buffer image after this edge: same-edge sample first, then zero padding.
   always_comb begin
      w_frame = r_fill;
      for (int i = 0; i < SAMPLES_PER_FRAME; i++) begin
         if (w_accept && (CNT_W'(i) == r_fill_cnt)) begin
            w_frame[i] = sample_in;
         end else if (w_flush && (CNT_W'(i) >= r_fill_cnt)) begin
            w_frame[i] = '0;
         end
      end
   end

   // Fill buffer, write index and pending-frame flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fill      <= '0;
         r_fill_cnt  <= '0;
         r_fill_full <= 1'b0;
      end else begin
         if (w_accept || w_flush) begin
            r_fill <= w_frame;
         end
         if (w_flush) begin
            r_fill_cnt <= '0;
         end else if (w_accept) begin
            r_fill_cnt <= r_fill_cnt + 1'b1;  // wraps to 0 after the last index
         end
         if (w_move) begin
            r_fill_full <= 1'b0;
         end else if (w_complete) begin
            r_fill_full <= 1'b1;
         end
      end
   end

   // Output slot: load a completed frame, or drop valid when downstream takes it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out       <= '0;
         r_out_valid <= 1'b0;
         r_addr_out  <= '0;
      end else if (w_move) begin
         r_out       <= w_frame;
         r_out_valid <= 1'b1;
         r_addr_out  <= w_addr_sel;
      end else if (r_out_valid && next_module_ready) begin
         r_out_valid <= 1'b0;  // data and address hold their last values
      end
   end

   // Next-frame address: advance on every move, otherwise follow load_base.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr_next <= '0;
      end else if (w_move) begin
         r_addr_next <= w_addr_sel + ADDR_W'(FRAME_BYTES);
      end else if (load_base) begin
         r_addr_next <= base_address;
      end
   end

   assign audio_out   = r_out;
   assign address_out = r_addr_out;
   assign done        = r_out_valid;

endmodule

// File: tb/tb_frame_packer.sv
// Directed bench for frame_packer: one task per scenario, inline checks,
// expected values hand-computed from the address/sample sequence driven.
module tb_frame_packer;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [15:0]       sample_in = '0;
   logic              sample_valid = 1'b0;
   logic              sample_ready;
   logic              flush = 1'b0;
   logic [31:0]       base_address = '0;
   logic              load_base = 1'b0;
   logic              next_module_ready = 1'b0;
   logic [31:0]       address_out;
   logic [31:0][15:0] audio_out;
   logic              done;

   int n_cmp = 0;
   int n_err = 0;

   frame_packer dut (
      .clk               (clk),
      .rst               (rst),
      .sample_in         (sample_in),
      .sample_valid      (sample_valid),
      .sample_ready      (sample_ready),
      .flush             (flush),
      .base_address      (base_address),
      .load_base         (load_base),
      .next_module_ready (next_module_ready),
      .address_out       (address_out),
      .audio_out         (audio_out),
      .done              (done)
   );

   always #5 clk = ~clk;

   // Advance one edge; inputs are changed and outputs sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Stream 32 consecutive samples first, first+1, ... one per cycle.
   task automatic send_frame(input logic [15:0] first);
      for (int i = 0; i < 32; i++) begin
         sample_in    = first + 16'(i);
         sample_valid = 1'b1;
         tick();
      end
      sample_valid = 1'b0;
   endtask

   task automatic do_load(input logic [31:0] base);
      base_address = base;
      load_base    = 1'b1;
      tick();
      load_base    = 1'b0;
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;
      #3;
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
      n_cmp++; if (sample_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", sample_ready); end
      n_cmp++; if (address_out !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", address_out); end
      n_cmp++; if (audio_out !== '0) begin n_err++; $display("FAIL reset_audio: got %h want 0", audio_out); end
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      next_module_ready = 1'b1;
      do_load(32'h1000);
      send_frame(16'd1);
      n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL basic_done: got %b want 1", done); end
      n_cmp++; if (audio_out[0] !== 16'd1) begin n_err++; $display("FAIL basic_a0: got %0d want 1", audio_out[0]); end
      n_cmp++; if (audio_out[31] !== 16'd32) begin n_err++; $display("FAIL basic_a31: got %0d want 32", audio_out[31]); end
      n_cmp++; if (address_out !== 32'h1000) begin n_err++; $display("FAIL basic_addr: got %h want 1000", address_out); end
      tick();
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_drop: got %b want 0", done); end
      n_cmp++; if (address_out !== 32'h1000) begin n_err++; $display("FAIL basic_hold_addr: got %h want 1000", address_out); end
   endtask

   task automatic test_backpressure();
      next_module_ready = 1'b0;
      send_frame(16'd100);
      n_cmp++; if (address_out !== 32'h1040) begin n_err++; $display("FAIL bp_addr1: got %h want 1040", address_out); end
      send_frame(16'd132);
      n_cmp++; if (sample_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_low: got %b want 0", sample_ready); end
      tick();
      tick();
      n_cmp++; if (sample_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_hold: got %b want 0", sample_ready); end
      n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL bp_done_hold: got %b want 1", done); end
      n_cmp++; if (address_out !== 32'h1040) begin n_err++; $display("FAIL bp_addr_stable: got %h want 1040", address_out); end
      n_cmp++; if (audio_out[0] !== 16'd100) begin n_err++; $display("FAIL bp_audio_stable: got %0d want 100", audio_out[0]); end
      next_module_ready = 1'b1;
      tick();
      n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL bp_no_bubble: got %b want 1", done); end
      n_cmp++; if (address_out !== 32'h1080) begin n_err++; $display("FAIL bp_addr2: got %h want 1080", address_out); end
      n_cmp++; if (audio_out[0] !== 16'd132) begin n_err++; $display("FAIL bp_audio2_0: got %0d want 132", audio_out[0]); end
      n_cmp++; if (audio_out[31] !== 16'd163) begin n_err++; $display("FAIL bp_audio2_31: got %0d want 163", audio_out[31]); end
      n_cmp++; if (sample_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_back: got %b want 1", sample_ready); end
      tick();
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL bp_drop: got %b want 0", done); end
   endtask

   task automatic test_flush();
      next_module_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         sample_in = 16'd7; sample_valid = 1'b1; tick();
      end
      sample_valid = 1'b0;
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL fl_partial: got %b want 0", done); end
      flush = 1'b1; tick(); flush = 1'b0;
      n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL fl_done: got %b want 1", done); end
      n_cmp++; if (audio_out[0] !== 16'd7 || audio_out[4] !== 16'd7) begin n_err++; $display("FAIL fl_data: got %0d %0d want 7 7", audio_out[0], audio_out[4]); end
      n_cmp++; if (audio_out[5] !== 16'd0 || audio_out[31] !== 16'd0) begin n_err++; $display("FAIL fl_pad: got %0d %0d want 0 0", audio_out[5], audio_out[31]); end
      n_cmp++; if (address_out !== 32'h10C0) begin n_err++; $display("FAIL fl_addr: got %h want 10c0", address_out); end
      tick();
      flush = 1'b1; tick(); flush = 1'b0;
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL fl_empty: got %b want 0", done); end
      tick();
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL fl_empty2: got %b want 0", done); end
      // flush together with a sample: the sample lands before the padding
      for (int i = 1; i <= 3; i++) begin
         sample_in = 16'(i); sample_valid = 1'b1; tick();
      end
      sample_in = 16'd9; flush = 1'b1; tick();
      sample_valid = 1'b0; flush = 1'b0;
      n_cmp++; if (audio_out[2] !== 16'd3 || audio_out[3] !== 16'd9) begin n_err++; $display("FAIL fl_same_edge: got %0d %0d want 3 9", audio_out[2], audio_out[3]); end
      n_cmp++; if (audio_out[4] !== 16'd0) begin n_err++; $display("FAIL fl_same_pad: got %0d want 0", audio_out[4]); end
      n_cmp++; if (address_out !== 32'h1100) begin n_err++; $display("FAIL fl_addr2: got %h want 1100", address_out); end
      tick();
   endtask

   task automatic test_wrap();
      next_module_ready = 1'b1;
      do_load(32'hFFFF_FFC0);
      send_frame(16'd500);
      n_cmp++; if (address_out !== 32'hFFFF_FFC0) begin n_err++; $display("FAIL wrap_a: got %h want ffffffc0", address_out); end
      send_frame(16'd600);
      n_cmp++; if (address_out !== 32'h0) begin n_err++; $display("FAIL wrap_b: got %h want 0", address_out); end
      n_cmp++; if (audio_out[0] !== 16'd600) begin n_err++; $display("FAIL wrap_data: got %0d want 600", audio_out[0]); end
      tick();
   endtask

   task automatic test_load_on_move();
      next_module_ready = 1'b1;
      for (int i = 0; i < 31; i++) begin
         sample_in = 16'(i); sample_valid = 1'b1; tick();
      end
      sample_in = 16'd31; base_address = 32'h2000; load_base = 1'b1; tick();
      load_base = 1'b0; sample_valid = 1'b0;
      n_cmp++; if (address_out !== 32'h2000) begin n_err++; $display("FAIL lom_a: got %h want 2000", address_out); end
      send_frame(16'd0);
      n_cmp++; if (address_out !== 32'h2040) begin n_err++; $display("FAIL lom_b: got %h want 2040", address_out); end
      tick();
   endtask

   task automatic test_reset_mid();
      next_module_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         sample_in = 16'd77; sample_valid = 1'b1; tick();
      end
      sample_valid = 1'b0;
      rst = 1'b1; #2;
      n_cmp++; if (sample_ready !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL rm_partial: got rdy=%b done=%b want 1 0", sample_ready, done); end
      tick(); rst = 1'b0; tick();
      next_module_ready = 1'b0;
      do_load(32'h3000);
      send_frame(16'd40);
      n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL rm_held: got %b want 1", done); end
      rst = 1'b1; #2;
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rm_done: got %b want 0", done); end
      n_cmp++; if (address_out !== 32'h0) begin n_err++; $display("FAIL rm_addr: got %h want 0", address_out); end
      n_cmp++; if (audio_out !== '0) begin n_err++; $display("FAIL rm_audio: got %h want 0", audio_out); end
      tick(); rst = 1'b0; tick();
      next_module_ready = 1'b1;
      send_frame(16'd1);
      n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL rm_fresh_done: got %b want 1", done); end
      n_cmp++; if (address_out !== 32'h0) begin n_err++; $display("FAIL rm_fresh_addr: got %h want 0", address_out); end
      n_cmp++; if (audio_out[0] !== 16'd1 || audio_out[31] !== 16'd32) begin n_err++; $display("FAIL rm_fresh_data: got %0d %0d want 1 32", audio_out[0], audio_out[31]); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_flush();
      test_wrap();
      test_load_on_move();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
